// File: rtl/serial_shifter_pkg.sv
// -----------------------------------------------------------------------------
// serial_shifter_pkg
//   Shared types for the serial shifter:
//     mode_e  : operation codes (LSL, LSR, ASR, ROL, ROR); codes 101..111 are
//               illegal and treated as pass-through.
//     state_e : controller states IDLE / SHIFT / DONE.
//     mode_legal() : tells whether an operation code is implemented in this
//               build. With SERIAL_SHIFTER_ROTATE_EN undefined, ROL and ROR
//               are reported illegal so they fall back to pass-through.
// -----------------------------------------------------------------------------
package serial_shifter_pkg;

  typedef enum logic [2:0] {
    MODE_LSL = 3'b000,
    MODE_LSR = 3'b001,
    MODE_ASR = 3'b010,
    MODE_ROL = 3'b011,
    MODE_ROR = 3'b100
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Highest operation code that this build actually implements.
`ifdef SERIAL_SHIFTER_ROTATE_EN
  localparam logic [2:0] MODE_LAST = MODE_ROR;
`else
  localparam logic [2:0] MODE_LAST = MODE_ASR;
`endif

  function automatic logic mode_legal(input logic [2:0] m);
    return (m <= MODE_LAST);
  endfunction

endpackage

// File: rtl/serial_shifter_step.sv
// -----------------------------------------------------------------------------
// shift_step
//   Purely combinational single-cycle shift of data_i by amt_i positions,
//   where amt_i is at most STEP. Produces the shifted word and the final
//   vacated bit, which stays cleared for a zero distance or an unimplemented
//   mode.
//   Built as a chain of STEP one-position stages so the "last vacated bit"
//   falls out naturally from the final active stage.
//
//   Parameters : WIDTH (data width), STEP (max positions per cycle),
//                AW (shift-amount width).
//   Ports      : data_i  in  WIDTH  word to shift
//                mode_i  in  3      operation code (mode_e)
//                amt_i   in  AW     positions to shift this cycle, 0..STEP
//                data_o  out WIDTH  shifted word
//                vac_o   out 1      last bit shifted/rotated out
//   Rotate stages exist only when SERIAL_SHIFTER_ROTATE_EN is defined.
// -----------------------------------------------------------------------------
module shift_step
  import serial_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       mode_i,
  input  logic [AW-1:0]    amt_i,
  output logic [WIDTH-1:0] data_o,
  output logic             vac_o
);

  logic [WIDTH-1:0] d;
  logic             v;

  always_comb begin
    d = data_i;
    v = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      // Stage i is active only while fewer than amt_i positions are done.
      if (i < int'(amt_i)) begin
        case (mode_i)
          MODE_LSL: begin
            v = d[WIDTH-1];
            d = {d[WIDTH-2:0], 1'b0};
          end
          MODE_LSR: begin
            v = d[0];
            d = {1'b0, d[WIDTH-1:1]};
          end
          MODE_ASR: begin
            v = d[0];
            d = {d[WIDTH-1], d[WIDTH-1:1]};
          end
`ifdef SERIAL_SHIFTER_ROTATE_EN
          MODE_ROL: begin
            v = d[WIDTH-1];
            d = {d[WIDTH-2:0], d[WIDTH-1]};
          end
          MODE_ROR: begin
            v = d[0];
            d = {d[0], d[WIDTH-1:1]};
          end
`endif
          default: begin
            v = 1'b0;
          end
        endcase
      end
    end
  end

  assign data_o = d;
  assign vac_o  = v;

endmodule

// File: rtl/serial_shifter.sv
// -----------------------------------------------------------------------------
// serial_shifter
//   Multi-cycle barrel-free shifter: an accepted request shifts the operand
//   by up to STEP positions per clock until the requested distance is done.
//   Supports LSL, LSR, ASR and (with SERIAL_SHIFTER_ROTATE_EN defined) ROL
//   and ROR. Illegal codes and zero distance complete immediately with the
//   operand passed through unchanged.
//
//   Parameters : WIDTH (>=2), STEP (1..WIDTH-1); AW = $clog2(WIDTH).
//   Ports      : clk    in   1      rising-edge clock
//                rst    in   1      asynchronous active-high reset
//                start  in   1      request, sampled while not busy
//                mode   in   3      000 LSL,001 LSR,010 ASR,011 ROL,100 ROR
//                amt    in   AW     shift distance 0..WIDTH-1
//                din    in   WIDTH  operand, captured on accept
//                busy   out  1      high while in SHIFT
//                done   out  1      one-cycle completion pulse
//                dout   out  WIDTH  result register
//                cout   out  1      last bit shifted/rotated out
//   Build option: SERIAL_SHIFTER_ROTATE_EN enables the rotate datapath.
// -----------------------------------------------------------------------------
module serial_shifter
  import serial_shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int STEP  = 1,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             cout
);

  // STEP < WIDTH <= 2**AW, so it always fits the shift-amount width.
  localparam logic [AW-1:0] STEP_A = AW'(STEP);

  state_e           state_q;
  logic [WIDTH-1:0] dout_q;
  logic             cout_q;
  logic [AW-1:0]    rem_q;
  logic [2:0]       mode_q;
  logic             busy_q;
  logic             done_q;

  // Positions to move on this SHIFT edge: min(remaining, STEP).
  logic [AW-1:0]    step_amt_d;
  logic [WIDTH-1:0] dout_d;
  logic             cout_d;
  logic             start_direct_done;

  assign step_amt_d = (rem_q > STEP_A) ? STEP_A : rem_q;

  // Zero distance or an unimplemented code skips SHIFT entirely.
  assign start_direct_done = (amt == '0) || !mode_legal(mode);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AW    (AW)
  ) u_step (
    .data_i (dout_q),
    .mode_i (mode_q),
    .amt_i  (step_amt_d),
    .data_o (dout_d),
    .vac_o  (cout_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
      cout_q  <= 1'b0;
      rem_q   <= '0;
      mode_q  <= MODE_LSL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          // start and operand inputs are deliberately ignored here.
          dout_q <= dout_d;
          cout_q <= cout_d;
          rem_q  <= rem_q - step_amt_d;
          if (rem_q == step_amt_d) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE lasts one cycle.
          if (start) begin
            dout_q <= din;
            rem_q  <= amt;
            mode_q <= mode;
            cout_q <= 1'b0;
            if (start_direct_done) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SHIFT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_shifter.md
SERIAL_SHIFTER -- requirements
Module: serial_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width, legal range >= 2.
REQ-002 SHALL have parameter STEP, default 1: maximum shift positions per cycle, legal range 1..WIDTH-1.
REQ-003 SHALL derive local constant AW = $clog2(WIDTH), the shift-amount width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  request; sampled only while busy=0.
REQ-008 mode  in  3  operation: 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR.
REQ-009 amt  in  AW  shift distance, 0..WIDTH-1.
REQ-010 din  in  WIDTH  operand, captured on start.
REQ-011 busy  out  1  high while shifting.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 dout  out  WIDTH  result register.
REQ-014 cout  out  1  last bit shifted or rotated out.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-016 Start SHALL be accepted in IDLE or DONE only, at edge E0; accept means: dout<=din, remaining count<=amt, mode latched, cout<=0.
REQ-017 Start SHALL be ignored in SHIFT; operands changing during SHIFT SHALL have no effect.
REQ-018 At E0, if amt=0 or mode is illegal, the FSM SHALL go directly to DONE; otherwise it SHALL go to SHIFT.
REQ-019 Each SHIFT edge SHALL move dout by s = min(remaining, STEP) and decrement remaining by s; the edge that brings remaining to 0 SHALL enter DONE.
REQ-020 Total latency SHALL be k = ceil(amt/STEP) shift edges, and done SHALL be high for exactly the one cycle after edge Ek.
REQ-021 busy SHALL equal (state==SHIFT).
REQ-022 DONE SHALL return to IDLE after one cycle unless start is accepted in it, in which case it goes to SHIFT or DONE per REQ-018.
REQ-023 Fill rules: LSL and LSR SHALL fill 0; ASR SHALL replicate the MSB; ROL and ROR SHALL wrap around.
REQ-024 On every shift edge, cout SHALL capture the last bit vacated; cout SHALL remain 0 for amt=0 and for illegal modes.
REQ-025 dout and cout SHALL hold their values from DONE until the next accepted start.
REQ-026 Mode codes 101 to 111 SHALL be illegal and behave as pass-through (dout=din, cout=0).

Reset
REQ-027 rst SHALL act immediately: state=IDLE, dout=0, cout=0, remaining=0, busy=0, done=0.
REQ-028 Reset during SHIFT SHALL abort the operation with no done pulse; start SHALL be accepted from the first edge after rst deasserts.

Configuration
REQ-029 Macro SERIAL_SHIFTER_ROTATE_EN defined: ROL and ROR SHALL be implemented per REQ-023.
REQ-030 Macro SERIAL_SHIFTER_ROTATE_EN undefined: codes 011 and 100 SHALL be illegal per REQ-026, and the rotate datapath SHALL be absent.

Structure
REQ-031 Package serial_shifter_pkg SHALL hold the mode enum (5 codes) and the FSM state enum.
REQ-032 The combinational single-cycle shift by 0..STEP for all modes SHALL be sub-module shift_step, which returns next data and the vacated bit; serial_shifter owns the FSM, counter and registers.

Verification (WIDTH=8 unless stated)
REQ-033 STEP=1, LSL, din=8'h96, amt=3 -> busy for 3 cycles, done after E3, dout=8'hB0, cout=0.
REQ-034 STEP=1, ASR, din=8'h90, amt=2 -> dout=8'hE4, cout=0, done after E2.
REQ-035 STEP=1, ROR, din=8'h81, amt=1 -> with macro: dout=8'hC0, cout=1; without macro: dout=8'h81, cout=0, done after E0.
REQ-036 STEP=4, LSR, din=8'hF0, amt=7 -> two shift edges (4 then 3), dout=8'h01, cout=1; a start pulsed mid-shift is ignored.
REQ-037 amt=0, then a back-to-back start issued in DONE -> first done after E0 with dout=din; second operation accepted with no IDLE cycle in between.
REQ-038 rst pulsed asynchronously mid-SHIFT -> busy=0, done=0, dout=8'h00 immediately, and no done pulse follows.
